// File: rtl/bf_pkg.sv
// Shared instruction encoding for the brainf*ck core (fetch/decode and execute).
package bf_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned IMM_W = 12;
  localparam int unsigned INS_W = OP_W + IMM_W;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_PLUS  = 4'h1;
  localparam logic [OP_W-1:0] OP_MINUS = 4'h2;
  localparam logic [OP_W-1:0] OP_INC   = 4'h3;
  localparam logic [OP_W-1:0] OP_DEC   = 4'h4;
  localparam logic [OP_W-1:0] OP_BRZ   = 4'h5;
  localparam logic [OP_W-1:0] OP_BRNZ  = 4'h6;
  localparam logic [OP_W-1:0] OP_GETC  = 4'h7;
  localparam logic [OP_W-1:0] OP_PRINT = 4'h8;
  localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

  function automatic logic [OP_W-1:0] ins_op(input logic [INS_W-1:0] ins);
    return ins[INS_W-1:IMM_W];
  endfunction

  function automatic logic [IMM_W-1:0] ins_imm(input logic [INS_W-1:0] ins);
    return ins[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/bf_ptr_file.sv
// Per-thread data pointer registers with one write port and a write-forwarding read port.
module bf_ptr_file #(
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned NTHREADS  = 4,
  parameter int unsigned PTR_RESET = 128,
  localparam int unsigned TID_W    = $clog2(NTHREADS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [TID_W-1:0] waddr,
  input  logic [PTR_W-1:0] wdata,
  input  logic [TID_W-1:0] raddr,
  output logic [PTR_W-1:0] rdata
);

  logic [PTR_W-1:0] ptr_q [NTHREADS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NTHREADS); i++) ptr_q[i] <= PTR_W'(PTR_RESET);
    end else if (we) begin
      ptr_q[waddr] <= wdata;
    end
  end

  // A pointer committing this cycle is seen by the instruction being accepted.
  assign rdata = (we && (waddr == raddr)) ? wdata : ptr_q[raddr];

endmodule

// File: rtl/bf_exec_unit.sv
// Multi-thread execute stage: pointer update, tape read-modify-write, branch resolve, PRINT/GETC handshakes.
module bf_exec_unit
  import bf_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned NTHREADS  = 4,
  parameter int unsigned PTR_RESET = 128,
  localparam int unsigned TID_W    = $clog2(NTHREADS),
  localparam int unsigned ADDR_W   = TID_W + PTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INS_W-1:0]    in_ins,
  input  logic [TID_W-1:0]    in_tid,
  input  logic [DATA_W-1:0]   in_val,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                br_en,
  output logic [TID_W-1:0]    br_tid,
  output logic [IMM_W-1:0]    br_target,
  output logic                print_valid,
  input  logic                print_ready,
  output logic [DATA_W-1:0]   print_data,
  output logic [TID_W-1:0]    print_tid,
  input  logic                getc_valid,
  output logic                getc_ready,
  input  logic [DATA_W-1:0]   getc_data,
  output logic [NTHREADS-1:0] halted
);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [IMM_W-1:0]    imm_q;
  logic [TID_W-1:0]    tid_q;
  logic [DATA_W-1:0]   cell_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [NTHREADS-1:0] halted_q, halted_d;

  logic                hold, complete, accept, drop;
  logic                ptr_we;
  logic [PTR_W-1:0]    ptr_wdata, ptr_fwd;
  logic [DATA_W-1:0]   amt_d, cell_in;
  logic [PTR_W-1:0]    amt_p;

  bf_ptr_file #(
    .PTR_W     (PTR_W),
    .NTHREADS  (NTHREADS),
    .PTR_RESET (PTR_RESET)
  ) u_ptr_file (
    .clk   (clk),
    .rst   (rst),
    .we    (ptr_we),
    .waddr (tid_q),
    .wdata (ptr_wdata),
    .raddr (in_tid),
    .rdata (ptr_fwd)
  );

  assign rd_addr = {in_tid, ptr_fwd};
  assign halted  = halted_q;
  assign hold    = (state_q == ST_HOLD);
  assign amt_d   = (imm_q == '0) ? DATA_W'(1) : DATA_W'(imm_q);
  assign amt_p   = (imm_q == '0) ? PTR_W'(1) : PTR_W'(imm_q);

  always_comb begin
    state_d     = state_q;
    complete    = 1'b0;
    ptr_we      = 1'b0;
    ptr_wdata   = ptr_q;
    halted_d    = halted_q;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    br_en       = 1'b0;
    br_tid      = '0;
    br_target   = '0;
    print_valid = 1'b0;
    print_data  = '0;
    print_tid   = '0;
    getc_ready  = 1'b0;

    if (hold) begin
      case (op_q)
        OP_PRINT: complete = print_ready;
        OP_GETC:  complete = getc_valid;
        default:  complete = 1'b1;
      endcase
    end

    in_ready = !hold || complete;
    accept   = in_valid && in_ready;

    if (hold) begin
      case (op_q)
        OP_PLUS: begin
          wb_en   = 1'b1;
          wb_data = cell_q + amt_d;
        end
        OP_MINUS: begin
          wb_en   = 1'b1;
          wb_data = cell_q - amt_d;
        end
        OP_GETC: begin
          getc_ready = 1'b1;
          wb_en      = getc_valid;
          wb_data    = getc_valid ? getc_data : '0;
        end
        OP_PRINT: begin
          print_valid = 1'b1;
          print_data  = cell_q;
          print_tid   = tid_q;
        end
        OP_INC: begin
          ptr_we    = 1'b1;
          ptr_wdata = ptr_q + amt_p;
        end
        OP_DEC: begin
          ptr_we    = 1'b1;
          ptr_wdata = ptr_q - amt_p;
        end
        OP_BRZ:  br_en = (cell_q == '0);
        OP_BRNZ: br_en = (cell_q != '0);
        OP_HALT: halted_d[tid_q] = 1'b1;
        default: ;
      endcase
    end

    if (wb_en) wb_addr = {tid_q, ptr_q};
    if (br_en) begin
      br_tid    = tid_q;
      br_target = imm_q;
    end

    // A cell written this cycle at the address being read supersedes the stale RAM data.
    cell_in = (wb_en && (wb_addr == rd_addr)) ? wb_data : in_val;
    // halted_d already includes a HALT of this thread completing now.
    drop    = halted_d[in_tid];

    if (hold && complete) state_d = ST_EMPTY;
    if (accept && !drop)  state_d = ST_HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      op_q     <= OP_NOP;
      imm_q    <= '0;
      tid_q    <= '0;
      cell_q   <= '0;
      ptr_q    <= '0;
      halted_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      if (accept && !drop) begin
        op_q   <= ins_op(in_ins);
        imm_q  <= ins_imm(in_ins);
        tid_q  <= in_tid;
        cell_q <= cell_in;
        ptr_q  <= ptr_fwd;
      end
    end
  end

endmodule
